sipo_frame_buffer: RTL and testbench
====================================

# sipo_frame_buffer

Parametrised serial-in/parallel-out frame buffer with a valid/ready input handshake, fill counter and frame-complete hold. Words stream in one per accepted beat and shift toward index 0; once LENGTH words have been accepted the full frame is frozen on `par_out` and presented to the parallel consumer, the coprocessor datapath, until that consumer acknowledges it. It is the handshaked successor of the free-running shift register on the coprocessor input path. It adds synchronous reset, frame boundaries, backpressure and flush.

## Interface
- `WIDTH`, 8, bits per word.
- `LENGTH`, 1024, words per frame; must be ≥ 2.
- `CNT_W`, `$clog2(LENGTH+1)`, width of `count`.

- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  WIDTH  serial word.
- `in_valid`  in  1  `in_data` valid this cycle.
- `in_ready`  out  1  block accepts a word this cycle.
- `frame_ack`  in  1  consumer has taken the frame.
- `flush`  in  1  abort the current frame.
- `par_out`  out  WIDTH × [LENGTH-1:0] unpacked  parallel frame; index 0 is the oldest word.
- `frame_valid`  out  1  `par_out` holds a complete frame.
- `count`  out  CNT_W  words accepted in the current frame, 0..LENGTH.

## Operation
- States: FILL (accepting) and FULL (holding). Reset state is FILL.
- Accept condition: `in_valid && in_ready`.
- `in_ready = (state == FILL) && !flush`. It is combinational and has no dependency on `in_valid`.
- Shift on accept:
  - `par_out[LENGTH-1] <= in_data`.
  - `par_out[k] <= par_out[k+1]` for k = 0..LENGTH-2.
  - `count <= count + 1`.
- FILL → FULL: on an accept while `count == LENGTH-1`. After that edge `count == LENGTH` and `frame_valid == 1`. The j-th accepted word of the frame (j = 0 first) sits at `par_out[j]`.
- In FULL:
  - `par_out` and `count` hold.
  - `in_valid` is ignored; the source must hold its word, which is legal backpressure and not an error.
- FULL → FILL: on `frame_ack`. Next cycle `count = 0`, `frame_valid = 0` and `in_ready = 1`.
  - `par_out` is not cleared. Stale words shift out as the new frame fills.
- `frame_ack` while in FILL is ignored.
- `flush`, in either state:
  - Next state is FILL and `count <= 0`.
  - `par_out` is not cleared.
  - A beat offered in the same cycle is not accepted, because `in_ready` is 0.
- Priority per edge: `rst` > `flush` > `frame_ack` > accept.
- Reset values: all `par_out` entries 0, `count` 0, `frame_valid` 0, state FILL.
  - `in_ready` is 1 in the first cycle after reset deasserts, unless `flush` is high.
  - Reset mid-frame or mid-hold discards everything at that edge.
- Counter arithmetic is unsigned. `count` never exceeds LENGTH and never wraps.

## Timing
- Throughput: one word per cycle in FILL with no bubbles. A LENGTH-word frame takes LENGTH cycles when `in_valid` is held high.
- `frame_valid` is registered. It rises the edge after the last accept, with zero extra latency from that edge.
- The ack turnaround costs one dead input cycle: an ack at edge t gives `in_ready` high in the cycle after edge t.
- Outputs `par_out`, `count` and `frame_valid` are registered. `in_ready` is the only combinational output.

## Test plan
- Fill: LENGTH=4, WIDTH=8, `in_valid` high continuously with data 0x11, 0x22, 0x33, 0x44 → after the 4th accept `par_out = {[0]=0x11, [1]=0x22, [2]=0x33, [3]=0x44}`, `count = 4`, `frame_valid = 1`, `in_ready = 0`.
- Backpressure and hold: in FULL, drive `in_valid = 1` with 0x55 for 5 cycles → `par_out` is unchanged and `count` stays 4. Then pulse `frame_ack` → next cycle `count = 0` and `in_ready = 1`, and 0x55 is accepted, giving `par_out[3] = 0x55` and `par_out[2] = 0x44`.
- Gapped input: `in_valid` pattern 1,0,0,1,1,0,1 → `count` steps 1,1,1,2,3,3,4. `frame_valid` rises only after the 4th accept.
- Flush: flush at `count = 2` with `in_valid = 1` → `in_ready = 0` that cycle, `count = 0` next cycle, and the offered word is not shifted in. Flush in FULL → `frame_valid = 0` and the block returns to FILL.
- Reset mid-frame: `rst` at `count = 3` → next cycle all `par_out` entries are 0, `count = 0` and `frame_valid = 0`. A `frame_ack` asserted in the same cycle as `rst` has no effect.
- Simultaneous events: in FULL, `frame_ack` and `flush` in the same cycle → result is FILL with `count = 0`. In FILL, `frame_ack` with an accept → the ack is ignored and `count` increments normally.

Source files
------------

// File: rtl/sipo_frame_buffer.sv
// rtl/sipo_frame_buffer.sv - serial-in/parallel-out frame buffer with valid/ready input and frame hold
// Words shift toward index 0; a full frame is frozen until frame_ack or flush.
module sipo_frame_buffer #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 1024,
  parameter int CNT_W  = $clog2(LENGTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             frame_ack,
  input  logic             flush,
  output logic [WIDTH-1:0] par_out [LENGTH-1:0],
  output logic             frame_valid,
  output logic [CNT_W-1:0] count
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LENGTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] buf_q [LENGTH-1:0];
  logic [WIDTH-1:0] buf_d [LENGTH-1:0];
  logic             accept;

  // Ready never looks at in_valid, so a source can wait on it without a loop.
  assign in_ready = (state_q == FILL) && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    buf_d   = buf_q;
    if (flush) begin
      state_d = FILL;
      count_d = '0;
    end else if (state_q == FULL) begin
      if (frame_ack) begin
        state_d = FILL;
        count_d = '0;
      end
    end else if (accept) begin
      for (int k = 0; k < LENGTH - 1; k++) begin
        buf_d[k] = buf_q[k+1];
      end
      buf_d[LENGTH-1] = in_data;
      count_d = count_q + CNT_W'(1);
      if (count_q == LAST_IDX) begin
        state_d = FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      count_q <= '0;
      for (int k = 0; k < LENGTH; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      buf_q   <= buf_d;
    end
  end

  assign par_out     = buf_q;
  assign count       = count_q;
  assign frame_valid = (state_q == FULL);

endmodule

// File: tb/tb_sipo_frame_buffer.sv
// tb/tb_sipo_frame_buffer.sv - directed bench for sipo_frame_buffer with LENGTH=4, WIDTH=8
// A behavioural model tracks registers; a queue holds accepted words until their frame completes.
module tb_sipo_frame_buffer;

  localparam int W = 8;
  localparam int L = 4;
  localparam int CW = $clog2(L + 1);

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         frame_ack;
  logic         flush;
  logic [W-1:0] par_out [L-1:0];
  logic         frame_valid;
  logic [CW-1:0] count;

  int total = 0;
  int bad = 0;

  logic [W-1:0] m_buf [L];
  int           m_cnt;
  bit           m_full;
  logic [W-1:0] sb_q [$];

  sipo_frame_buffer #(.WIDTH(W), .LENGTH(L)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .frame_ack(frame_ack),
    .flush(flush),
    .par_out(par_out),
    .frame_valid(frame_valid),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    chk("count", 32'(count), 32'(m_cnt));
    chk("frame_valid", 32'(frame_valid), 32'(m_full));
    for (int j = 0; j < L; j++) begin
      chk($sformatf("par_out[%0d]", j), 32'(par_out[j]), 32'(m_buf[j]));
    end
  endtask

  // One clock: check ready, advance the model with the driven inputs, then compare after the edge.
  task automatic tick();
    bit acc;
    bit was_full;
    logic [W-1:0] exp_w;
    #1;
    if (!rst) chk("in_ready", 32'(in_ready), 32'(!m_full && !flush));
    was_full = m_full;
    acc = in_valid && !m_full && !flush;
    if (rst) begin
      for (int j = 0; j < L; j++) m_buf[j] = '0;
      m_cnt = 0;
      m_full = 0;
      sb_q.delete();
    end else if (flush) begin
      m_cnt = 0;
      m_full = 0;
      sb_q.delete();
    end else if (m_full) begin
      if (frame_ack) begin
        m_full = 0;
        m_cnt = 0;
      end
    end else if (acc) begin
      for (int j = 0; j < L - 1; j++) m_buf[j] = m_buf[j+1];
      m_buf[L-1] = in_data;
      sb_q.push_back(in_data);
      m_cnt++;
      if (m_cnt == L) m_full = 1;
    end
    @(posedge clk);
    #1;
    check_regs();
    if (!was_full && m_full) begin
      for (int j = 0; j < L; j++) begin
        exp_w = sb_q.pop_front();
        chk($sformatf("sb_frame[%0d]", j), 32'(par_out[j]), 32'(exp_w));
      end
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] gap_valid [7];
    int           gap_cnt [7];
    gap_valid = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1};
    gap_cnt = '{1, 1, 1, 2, 3, 3, 4};
    for (int j = 0; j < L; j++) m_buf[j] = '0;
    m_cnt = 0;
    m_full = 0;
    rst = 1'b1;
    in_data = '0;
    in_valid = 1'b0;
    frame_ack = 1'b0;
    flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_fv", 32'(frame_valid), 0);
    chk("rst_par0", 32'(par_out[0]), 0);
    #1;
    chk("rst_ready", 32'(in_ready), 1);

    // Continuous fill
    in_valid = 1'b1;
    in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33; tick();
    in_data = 8'h44; tick();
    chk("fill_p0", 32'(par_out[0]), 32'h11);
    chk("fill_p1", 32'(par_out[1]), 32'h22);
    chk("fill_p2", 32'(par_out[2]), 32'h33);
    chk("fill_p3", 32'(par_out[3]), 32'h44);
    chk("fill_cnt", 32'(count), 4);
    chk("fill_fv", 32'(frame_valid), 1);

    // Backpressure while holding
    in_data = 8'h55;
    #1;
    chk("full_ready", 32'(in_ready), 0);
    for (int i = 0; i < 5; i++) tick();
    chk("hold_cnt", 32'(count), 4);
    chk("hold_p3", 32'(par_out[3]), 32'h44);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("ack_cnt", 32'(count), 0);
    chk("ack_fv", 32'(frame_valid), 0);
    #1;
    chk("ack_ready", 32'(in_ready), 1);
    tick();
    chk("resume_p3", 32'(par_out[3]), 32'h55);
    chk("resume_p2", 32'(par_out[2]), 32'h44);
    chk("resume_cnt", 32'(count), 1);

    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Gapped input
    for (int i = 0; i < 7; i++) begin
      in_valid = gap_valid[i][0];
      in_data = 8'hA0 + 8'(i);
      tick();
      chk($sformatf("gap_cnt[%0d]", i), 32'(count), 32'(gap_cnt[i]));
      chk($sformatf("gap_fv[%0d]", i), 32'(frame_valid), 32'(i == 6));
    end
    in_valid = 1'b0;

    // Flush while full
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flushfull_fv", 32'(frame_valid), 0);
    chk("flushfull_cnt", 32'(count), 0);

    // Flush mid-frame with a beat offered
    push_word(8'h61);
    push_word(8'h62);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h63;
    #1;
    chk("flush_ready", 32'(in_ready), 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_cnt", 32'(count), 0);
    chk("flush_p3", 32'(par_out[3]), 32'h62);

    // Reset mid-frame together with an ack
    push_word(8'h71);
    push_word(8'h72);
    push_word(8'h73);
    chk("pre_rst_cnt", 32'(count), 3);
    rst = 1'b1;
    frame_ack = 1'b1;
    tick();
    rst = 1'b0;
    frame_ack = 1'b0;
    chk("rstmid_cnt", 32'(count), 0);
    chk("rstmid_fv", 32'(frame_valid), 0);
    for (int j = 0; j < L; j++) chk($sformatf("rstmid_p%0d", j), 32'(par_out[j]), 0);

    // Ack and flush together while full
    for (int i = 0; i < L; i++) push_word(8'h80 + 8'(i));
    chk("full2_fv", 32'(frame_valid), 1);
    frame_ack = 1'b1;
    flush = 1'b1;
    tick();
    frame_ack = 1'b0;
    flush = 1'b0;
    chk("ackflush_cnt", 32'(count), 0);
    chk("ackflush_fv", 32'(frame_valid), 0);

    // Ack in FILL alongside an accept is ignored
    frame_ack = 1'b1;
    push_word(8'h77);
    frame_ack = 1'b0;
    chk("fillack_cnt", 32'(count), 1);
    chk("fillack_p3", 32'(par_out[3]), 32'h77);

    // Random frame through the scoreboard
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < L; i++) push_word(8'($urandom_range(0, 255)));
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("sb_empty", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
